// File: rtl/rv_pkg.sv
// Shared RV definitions: opcode constants, fetch state encoding, instruction width.
package rv_pkg;

  localparam int INSTR_W = 32;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  function automatic logic [6:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[6:0];
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC selection: sequential pc+4 or word-aligned branch target.
module fetch_pc_reg #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] aligned_target;
  logic [ADDR_W-1:0] next_pc;

  // the low two bits are dropped so pc stays word aligned; +4 wraps naturally
  assign seq_pc         = pc + ADDR_W'(4);
  assign aligned_target = branch_target & ~ADDR_W'(3);
  assign next_pc        = branch_taken ? aligned_target : seq_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (advance) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, instruction register, valid/ready to decode.
// Optional FETCH_MISALIGN_CHECK_EN traps misaligned branch targets into a sticky fault.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [6:0]         opcode,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               fetch_fault
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              transfer;
  logic              misalign;
  logic              pc_advance;

  assign transfer = instr_valid & instr_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = branch_taken & (branch_target[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // a faulting redirect leaves pc pointing at the last good fetch
  assign pc_advance = transfer & ~misalign;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .advance       (pc_advance),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc)
  );

  assign imem_addr = pc;
  assign opcode    = opcode_of(instr);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // rvalid here is a protocol violation and is deliberately ignored
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (misalign) begin
`ifdef FETCH_MISALIGN_CHECK_EN
              fault_q  <= 1'b1;
              state    <= S_FAULT;
`endif
              imem_req <= 1'b0;
            end else begin
              imem_req <= 1'b1;
              state    <= S_REQ;
            end
          end
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        S_FAULT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
`endif
        default: begin
          state       <= S_IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a randomized memory and downstream.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] instr_pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        fetch_fault;

  int          assert_cnt = 0;
  int          fail_cnt   = 0;
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .opcode        (opcode),
    .instr_pc      (instr_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .fetch_fault   (fetch_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // memory side: wait (bounded) for a request, then answer after lat cycles
  task automatic fetch(input int lat, input logic [31:0] data,
                       output bit ok, output logic [31:0] addr_seen);
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    ok = (imem_req === 1'b1);
    addr_seen = imem_addr;
    for (int i = 1; i < lat; i++) step();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
  endtask

  task automatic transfer(input bit br, input logic [31:0] tgt);
    instr_ready   = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    step();
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = $urandom;
    model_pc = br ? (tgt & 32'hFFFF_FFFC) : model_pc + 32'd4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    step(); step();
    assert_cnt++; if (imem_req !== 1'b0) begin fail_cnt++; $display("FAIL reset_req: got %b exp 0", imem_req); end
    assert_cnt++; if (instr_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
    assert_cnt++; if ({instr, opcode, instr_pc} !== '0) begin fail_cnt++; $display("FAIL reset_regs: instr %h opcode %h pc %h exp 0", instr, opcode, instr_pc); end
    assert_cnt++; if (fetch_fault !== 1'b0) begin fail_cnt++; $display("FAIL reset_fault: got %b exp 0", fetch_fault); end
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    model_pc = 32'h0;
    assert_cnt++; if (imem_req !== 1'b1 || imem_addr !== model_pc) begin fail_cnt++; $display("FAIL idle_to_req: req %b addr %h exp 1 %h", imem_req, imem_addr, model_pc); end
    step();
    assert_cnt++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin fail_cnt++; $display("FAIL idle_rvalid_ignored: valid %b instr %h exp 0 0", instr_valid, instr); end
  endtask

  task automatic test_basic();
    bit ok; logic [31:0] a;
    instr_ready = 1'b1;
    fetch(1, 32'h0000_0033, ok, a);
    assert_cnt++; if (!ok || a !== 32'h0) begin fail_cnt++; $display("FAIL basic_addr: ok %b addr %h exp 0", ok, a); end
    assert_cnt++; if (instr_valid !== 1'b1 || opcode !== 7'h33 || instr_pc !== 32'h0) begin fail_cnt++; $display("FAIL basic_out: valid %b opcode %h pc %h exp 1 33 0", instr_valid, opcode, instr_pc); end
    step();
    instr_ready = 1'b0;
    model_pc = model_pc + 32'd4;
    assert_cnt++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin fail_cnt++; $display("FAIL basic_next: valid %b req %b addr %h exp 0 1 4", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_backpressure();
    bit ok; logic [31:0] a; logic [31:0] d;
    d = $urandom;
    fetch($urandom_range(1, 4), d, ok, a);
    assert_cnt++; if (!ok || a !== model_pc) begin fail_cnt++; $display("FAIL bp_addr: ok %b addr %h exp %h", ok, a, model_pc); end
    for (int i = 0; i < 5; i++) begin
      branch_taken = 1'b1; branch_target = $urandom;
      imem_rvalid = 1'b1;  imem_rdata = ~d;
      step();
      assert_cnt++; if (instr !== d || instr_pc !== model_pc || instr_valid !== 1'b1) begin fail_cnt++; $display("FAIL bp_stable: instr %h pc %h valid %b exp %h %h 1", instr, instr_pc, instr_valid, d, model_pc); end
      assert_cnt++; if (imem_req !== 1'b0) begin fail_cnt++; $display("FAIL bp_no_req: got %b exp 0", imem_req); end
    end
    imem_rvalid = 1'b0; branch_taken = 1'b0;
    transfer(1'b0, 32'h0);
    assert_cnt++; if (imem_req !== 1'b1 || imem_addr !== model_pc) begin fail_cnt++; $display("FAIL bp_next: req %b addr %h exp 1 %h", imem_req, imem_addr, model_pc); end
  endtask

  task automatic test_redirect();
    bit ok; logic [31:0] a; logic [31:0] d;
    branch_taken = 1'b1; branch_target = 32'h80;
    step(); step();
    branch_taken = 1'b0;
    assert_cnt++; if (imem_addr !== 32'h8) begin fail_cnt++; $display("FAIL redir_no_xfer: addr %h exp 8", imem_addr); end
    d = $urandom;
    fetch(2, d, ok, a);
    assert_cnt++; if (!ok || a !== 32'h8 || instr_pc !== 32'h8 || instr !== d) begin fail_cnt++; $display("FAIL redir_fetch: addr %h pc %h instr %h exp 8 8 %h", a, instr_pc, instr, d); end
    transfer(1'b1, 32'h40);
    assert_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin fail_cnt++; $display("FAIL redir_target: req %b addr %h exp 1 40", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    bit ok; logic [31:0] a;
    fetch(1, $urandom, ok, a);
    transfer(1'b1, 32'hFFFF_FFFC);
    fetch(3, 32'h0000_0013, ok, a);
    assert_cnt++; if (!ok || instr_pc !== 32'hFFFF_FFFC || opcode !== 7'h13) begin fail_cnt++; $display("FAIL wrap_fetch: pc %h opcode %h exp fffffffc 13", instr_pc, opcode); end
    transfer(1'b0, 32'h0);
    assert_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fail_cnt++; $display("FAIL wrap_next: req %b addr %h exp 1 0", imem_req, imem_addr); end
  endtask

  task automatic test_random();
    bit ok; logic [31:0] a; logic [31:0] d; logic [31:0] tgt; bit br;
    for (int it = 0; it < 40; it++) begin
      d = $urandom;
      fetch($urandom_range(1, 4), d, ok, a);
      assert_cnt++; if (!ok || a !== model_pc) begin fail_cnt++; $display("FAIL rnd_addr[%0d]: ok %b addr %h exp %h", it, ok, a, model_pc); end
      assert_cnt++; if (instr_valid !== 1'b1 || instr !== d || opcode !== d[6:0] || instr_pc !== model_pc) begin fail_cnt++; $display("FAIL rnd_out[%0d]: valid %b instr %h pc %h exp 1 %h %h", it, instr_valid, instr, instr_pc, d, model_pc); end
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        branch_taken = $urandom_range(0, 1); branch_target = $urandom;
        step();
        assert_cnt++; if (instr !== d || instr_valid !== 1'b1) begin fail_cnt++; $display("FAIL rnd_hold[%0d]: instr %h valid %b exp %h 1", it, instr, instr_valid, d); end
      end
      branch_taken = 1'b0;
      br = ($urandom_range(0, 3) == 0);
`ifdef FETCH_MISALIGN_CHECK_EN
      tgt = $urandom & 32'hFFFF_FFFC;
`else
      tgt = $urandom;
`endif
      transfer(br, tgt);
      assert_cnt++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== model_pc) begin fail_cnt++; $display("FAIL rnd_next[%0d]: valid %b req %b addr %h exp 0 1 %h", it, instr_valid, imem_req, imem_addr, model_pc); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [31:0] a; logic [31:0] d;
    fetch(1, $urandom, ok, a);
    transfer(1'b1, 32'h10);
    assert_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin fail_cnt++; $display("FAIL rmid_setup: req %b addr %h exp 1 10", imem_req, imem_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    assert_cnt++; if (imem_req !== 1'b0) begin fail_cnt++; $display("FAIL rmid_async_drop: got %b exp 0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    step(); step();
    rst_n = 1'b1;
    step();
    imem_rvalid = 1'b0;
    model_pc = 32'h0;
    assert_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0) begin fail_cnt++; $display("FAIL rmid_stray: req %b addr %h valid %b instr %h exp 1 0 0 0", imem_req, imem_addr, instr_valid, instr); end
    d = $urandom;
    fetch(1, d, ok, a);
    assert_cnt++; if (!ok || instr !== d || instr_pc !== 32'h0) begin fail_cnt++; $display("FAIL rmid_refetch: instr %h pc %h exp %h 0", instr, instr_pc, d); end
  endtask

  task automatic test_misalign();
    bit ok; logic [31:0] a;
    transfer(1'b0, 32'h0);
    fetch(1, $urandom, ok, a);
    transfer(1'b0, 32'h0);
    fetch(2, $urandom, ok, a);
    transfer(1'b0, 32'h0);
    fetch(1, $urandom, ok, a);
    assert_cnt++; if (!ok || instr_pc !== 32'hC) begin fail_cnt++; $display("FAIL mis_setup: pc %h exp c", instr_pc); end
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h42;
    step();
    instr_ready = 1'b0; branch_taken = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    assert_cnt++; if (fetch_fault !== 1'b1 || instr_valid !== 1'b0) begin fail_cnt++; $display("FAIL mis_fault: fault %b valid %b exp 1 0", fetch_fault, instr_valid); end
    for (int i = 0; i < 4; i++) begin
      imem_rvalid = 1'b1;
      step();
      assert_cnt++; if (imem_req !== 1'b0 || imem_addr !== 32'hC || fetch_fault !== 1'b1) begin fail_cnt++; $display("FAIL mis_stuck: req %b addr %h fault %b exp 0 c 1", imem_req, imem_addr, fetch_fault); end
    end
    imem_rvalid = 1'b0;
`else
    assert_cnt++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin fail_cnt++; $display("FAIL mis_forced_align: fault %b req %b addr %h exp 0 1 40", fetch_fault, imem_req, imem_addr); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_random();
    test_reset_mid();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
